// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave
// I2C target that answers a single fixed 7-bit address. SCL and SDA are
// oversampled on clk. SDA is only ever pulled low or released. This block
// never stretches SCL.
//
// Ports
//   clk      in     system clock (SCL phases are each >= 8 clk periods)
//   rst      in     synchronous active-high reset
//   scl      in     bus clock
//   sda      inout  bus data, driven 1'b0 or 1'bz only
//   tx_data  in     [7:0] read byte, sampled on the cycle tx_req is high
//   rx_data  out    [7:0] last byte written by the controller
//   rx_valid out    one-cycle pulse when rx_data updates
//   tx_req   out    one-cycle pulse requesting the next read byte
//   busy     out    high from an address match until STOP
// ---------------------------------------------------------------------------
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    state_t     r_state;
    logic       r_scl_s1;
    logic       r_scl_s2;
    logic       r_scl_d;
    logic       r_sda_s1;
    logic       r_sda_s2;
    logic       r_sda_d;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_phase;
    logic       r_sda_low;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
    logic       r_busy;

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    // Two-flop synchronizers followed by one history flop for edge detection.
    // Reset to the idle-bus level so no spurious edge is seen after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    // SCL must be high on both samples so an SCL edge coinciding with an
    // SDA edge is never mistaken for a bus condition.
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

    // Protocol FSM; all outputs and the SDA pull-down are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_phase    <= 1'b0;
            r_sda_low  <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            if (w_start) begin
                // busy is left alone until the next address compare
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_phase   <= 1'b0;
                r_sda_low <= 1'b0;
            end else if (w_stop) begin
                // a partially shifted byte is simply dropped
                r_state   <= ST_IDLE;
                r_bit_cnt <= 4'd0;
                r_phase   <= 1'b0;
                r_sda_low <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_low <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= {r_shift[6:0], r_sda_s2};
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_rw      <= r_sda_s2;
                                r_phase   <= 1'b0;
                                // the first seven bits already sit in r_shift[6:0]
                                if (r_shift[6:0] == SLAVE_ADDR) begin
                                    r_busy  <= 1'b1;
                                    r_state <= ST_ADDR_ACK;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_state <= ST_WAIT_STOP;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        // first falling edge pulls SDA low, second releases it
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_low <= 1'b1;
                                r_phase   <= 1'b1;
                            end else begin
                                r_sda_low <= 1'b0;
                                r_phase   <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                if ((r_state == ST_ADDR_ACK) && r_rw) begin
                                    r_tx_req <= 1'b1;
                                    r_state  <= ST_RD_DATA;
                                end else begin
                                    r_state  <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift <= {r_shift[6:0], r_sda_s2};
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt  <= 4'd0;
                                r_rx_data  <= {r_shift[6:0], r_sda_s2};
                                r_rx_valid <= 1'b1;
                                r_phase    <= 1'b0;
                                r_state    <= ST_WR_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        // tx_data is taken while tx_req is high, one clk after
                        // the falling edge; SCL is still low for several clks.
                        if (r_tx_req) begin
                            r_shift   <= tx_data;
                            r_sda_low <= ~tx_data[7];
                        end else if (w_scl_rise) begin
                            if (r_bit_cnt != 4'd8) begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt;
                            end
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_low <= 1'b0;
                                r_phase   <= 1'b0;
                                r_state   <= ST_RD_ACK;
                            end else begin
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_sda_low <= ~r_shift[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // r_phase marks an ACK seen on the rising edge
                        if (w_scl_rise) begin
                            if (r_sda_s2) begin
                                r_sda_low <= 1'b0;
                                r_state   <= ST_WAIT_STOP;
                            end else begin
                                r_phase <= 1'b1;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_phase   <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_sda_low <= 1'b0;
                            r_tx_req  <= 1'b1;
                            r_state   <= ST_RD_DATA;
                        end
                    end
                    ST_WAIT_STOP: begin
                        r_sda_low <= 1'b0;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda      = r_sda_low ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave
// Directed plus randomized bench for i2c_slave. The bench plays the bus
// controller; expected values come from the I2C rules (ACK only for address
// 0x50, written bytes appear on rx_data, read bytes come from tx_data,
// unmatched reads return 0xFF from the pull-up).
// ---------------------------------------------------------------------------
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_low;
    logic [7:0] tx_data;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        tx_req;
    wire        busy;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_rxv = 0;
    int         n_txr = 0;
    int         n_busy_fall = 0;
    logic       busy_d = 1'b0;
    logic       dut_low_seen = 1'b0;
    logic [7:0] rx_q[$];

    // Bus monitor: counts pulses and notices any SDA pull-down by the target.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_rxv++;
            rx_q.push_back(rx_data);
        end
        if (tx_req === 1'b1) n_txr++;
        if (busy_d === 1'b1 && busy === 1'b0) n_busy_fall++;
        busy_d = busy;
        if (sda === 1'b0 && m_low == 1'b0) dut_low_seen = 1'b1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            m_low = 1'b0; clks(5); scl = 1'b1; clks(10);
        end
        m_low = 1'b1; clks(10); scl = 1'b0; clks(5);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; clks(5); scl = 1'b1; clks(10); m_low = 1'b0; clks(10);
    endtask

    task automatic put_bit(input logic b);
        m_low = ~b; clks(5); scl = 1'b1; clks(10); scl = 1'b0; clks(5);
    endtask

    task automatic get_bit(output logic b);
        m_low = 1'b0; clks(5); scl = 1'b1; clks(5);
        @(negedge clk);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        clks(5); scl = 1'b0; clks(5);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic rd8(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] got;
        logic [7:0] exp_b;
        logic [6:0] addr;
        logic       rw;
        logic       match;
        int         nb;
        int         rxv0;
        int         txr0;
        int         bf0;

        rst = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
        clks(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_tx_req", {31'd0, tx_req}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_sda", {31'd0, sda}, 32'd1);
        clks(5);

        // single-byte write
        rxv0 = n_rxv; rx_q.delete();
        bus_start();
        wr_byte(8'hA0, ack);
        chk("wr_addr_ack", {31'd0, ack}, 32'd0);
        chk("wr_busy_after_ack", {31'd0, busy}, 32'd1);
        wr_byte(8'h3C, ack);
        chk("wr_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        chk("wr_rxv_count", n_rxv - rxv0, 32'd1);
        chk("wr_rx_data", {24'd0, (rx_q.size() > 0) ? rx_q[0] : 8'hxx}, 32'h3C);
        chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);

        // address mismatch
        rxv0 = n_rxv; dut_low_seen = 1'b0;
        bus_start();
        wr_byte(8'hA2, ack);
        chk("mis_addr_nack", {31'd0, ack}, 32'd1);
        chk("mis_busy", {31'd0, busy}, 32'd0);
        wr_byte(8'hFF, ack);
        bus_stop();
        chk("mis_no_drive", {31'd0, dut_low_seen}, 32'd0);
        chk("mis_no_rxv", n_rxv - rxv0, 32'd0);

        // two-byte read
        txr0 = n_txr;
        tx_data = 8'h96;
        bus_start();
        wr_byte(8'hA1, ack);
        chk("rd_addr_ack", {31'd0, ack}, 32'd0);
        rd8(got);
        chk("rd_byte1", {24'd0, got}, 32'h96);
        tx_data = 8'h5A;
        put_bit(1'b0);
        rd8(got);
        chk("rd_byte2", {24'd0, got}, 32'h5A);
        put_bit(1'b1);
        clks(3);
        chk("rd_released_after_nack", {31'd0, sda}, 32'd1);
        bus_stop();
        chk("rd_txreq_count", n_txr - txr0, 32'd2);

        // repeated START
        rxv0 = n_rxv; rx_q.delete(); bf0 = n_busy_fall;
        bus_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h11, ack);
        tx_data = 8'hC3;
        bus_start();
        wr_byte(8'hA1, ack);
        chk("rs_addr_ack", {31'd0, ack}, 32'd0);
        rd8(got);
        chk("rs_read", {24'd0, got}, 32'hC3);
        put_bit(1'b1);
        chk("rs_busy_continuous", n_busy_fall - bf0, 32'd0);
        bus_stop();
        chk("rs_rxv_count", n_rxv - rxv0, 32'd1);
        chk("rs_rx_data", {24'd0, (rx_q.size() > 0) ? rx_q[0] : 8'hxx}, 32'h11);

        // abort after 4 data bits, then a clean write
        rxv0 = n_rxv; rx_q.delete();
        bus_start();
        wr_byte(8'hA0, ack);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        bus_stop();
        chk("abort_no_rxv", n_rxv - rxv0, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sda", {31'd0, sda}, 32'd1);
        bus_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h77, ack);
        bus_stop();
        chk("abort_next_rx", {24'd0, (rx_q.size() > 0) ? rx_q[0] : 8'hxx}, 32'h77);

        // reset while the target holds the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(((8'hA0 >> i) & 8'h01) != 8'h00);
        m_low = 1'b0;
        @(negedge clk);
        chk("rst_ack_driven", {31'd0, sda}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sda_released", {31'd0, sda}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        rst = 1'b0;
        clks(3);
        bus_stop();
        rx_q.delete();
        exp_b = 8'($urandom);
        bus_start();
        wr_byte(8'hA0, ack);
        chk("post_rst_ack", {31'd0, ack}, 32'd0);
        wr_byte(exp_b, ack);
        bus_stop();
        chk("post_rst_rx", {24'd0, (rx_q.size() > 0) ? rx_q[0] : 8'hxx}, {24'd0, exp_b});

        // randomized transactions against the rule-based model
        for (int t = 0; t < 8; t++) begin
            rw    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 3) != 0) ? 7'h50 : 7'($urandom);
            match = (addr == 7'h50);
            nb    = $urandom_range(1, 3);
            rxv0  = n_rxv; txr0 = n_txr; rx_q.delete();
            tx_data = 8'($urandom);
            bus_start();
            wr_byte({addr, rw}, ack);
            chk("rnd_addr_ack", {31'd0, ack}, {31'd0, ~match});
            for (int j = 0; j < nb; j++) begin
                if (rw) begin
                    exp_b = match ? tx_data : 8'hFF;
                    rd8(got);
                    chk("rnd_read", {24'd0, got}, {24'd0, exp_b});
                    tx_data = 8'($urandom);
                    put_bit(j == nb - 1);
                end else begin
                    exp_b = 8'($urandom);
                    wr_byte(exp_b, ack);
                    chk("rnd_wr_ack", {31'd0, ack}, {31'd0, ~match});
                    if (match) begin
                        chk("rnd_rx", {24'd0, (rx_q.size() > j) ? rx_q[j] : 8'hxx}, {24'd0, exp_b});
                    end
                end
            end
            bus_stop();
            chk("rnd_rxv_count", n_rxv - rxv0, (match && !rw) ? nb : 0);
            chk("rnd_txr_count", n_txr - txr0, (match && rw) ? nb : 0);
            chk("rnd_busy_idle", {31'd0, busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
